// File: rtl/slc3_io_pkg.sv
// Shared types and helpers for the SLC-3 operator front-panel logic.
package slc3_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    ACK
  } io_state_t;

  localparam int SW_WIDTH_DEFAULT = 10;

  function automatic int dbc_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stability counter for one active-low button.
// level idles high (released); rise/fall strobe for the cycle after a flip.
module button_debounce
  import slc3_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = dbc_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             level_d_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      level_reg   <= 1'b1;
      level_d_reg <= 1'b1;
      cnt_reg     <= '0;
    end else begin
      sync1_reg   <= btn;
      sync2_reg   <= sync1_reg;
      level_d_reg <= level_reg;
      // Flip only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          level_reg <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign level = level_reg;
  assign rise  = level_reg & ~level_d_reg;
  assign fall  = ~level_reg & level_d_reg;

endmodule

// File: rtl/io_operator_ctrl.sv
// Front-panel responder: debounced Run/Continue events, soft reset and the
// four-phase pause/continue handshake with SW capture and LED pause display.
module io_operator_ctrl
  import slc3_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int SW_WIDTH        = SW_WIDTH_DEFAULT
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Run,
  input  logic                Continue,
  input  logic [SW_WIDTH-1:0] SW,
  input  logic                pause_req,
  input  logic [SW_WIDTH-1:0] pause_code,
  output logic                soft_reset,
  output logic                run_start,
  output logic                resume,
  output logic [SW_WIDTH-1:0] sw_data,
  output logic [SW_WIDTH-1:0] LED
);

  logic run_lvl, run_rise, run_fall;
  logic cont_lvl, cont_rise, cont_fall;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk   (Clk),
    .rst_n (Reset_n),
    .btn   (Run),
    .level (run_lvl),
    .rise  (run_rise),
    .fall  (run_fall)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cont_db (
    .clk   (Clk),
    .rst_n (Reset_n),
    .btn   (Continue),
    .level (cont_lvl),
    .rise  (cont_rise),
    .fall  (cont_fall)
  );

  io_state_t           state_reg, state_next;
  logic                capture;
  logic                resume_next;
  logic                soft_now;
  logic                swallow_reg;
  logic                soft_reset_reg, run_start_reg, resume_reg;
  logic [SW_WIDTH-1:0] sw_sync1_reg, sw_sync2_reg;
  logic [SW_WIDTH-1:0] sw_data_reg, led_reg;

  assign soft_now = ~run_lvl & ~cont_lvl;

  always_comb begin
    state_next  = state_reg;
    capture     = 1'b0;
    resume_next = 1'b0;
    if (soft_now) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pause_req) state_next = WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (!pause_req) begin
            state_next = IDLE;
          end else if (cont_fall) begin
            capture    = 1'b1;
            state_next = WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (!pause_req) begin
            state_next = IDLE;
          end else if (cont_rise) begin
            resume_next = 1'b1;
            state_next  = ACK;
          end
        end
        ACK: begin
          if (!pause_req) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg      <= IDLE;
      sw_sync1_reg   <= '0;
      sw_sync2_reg   <= '0;
      soft_reset_reg <= 1'b0;
      swallow_reg    <= 1'b0;
      run_start_reg  <= 1'b0;
      resume_reg     <= 1'b0;
      sw_data_reg    <= '0;
      led_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      sw_sync1_reg   <= SW;
      sw_sync2_reg   <= sw_sync1_reg;
      soft_reset_reg <= soft_now;
      // The first Run release after a soft reset ends it and must not start the CPU.
      if (soft_now) begin
        swallow_reg <= 1'b1;
      end else if (run_rise) begin
        swallow_reg <= 1'b0;
      end
      run_start_reg <= run_rise & cont_lvl & ~soft_now & ~swallow_reg;
      resume_reg    <= resume_next;
      if (capture) sw_data_reg <= sw_sync2_reg;
      led_reg <= (state_reg == WAIT_PRESS || state_reg == WAIT_RELEASE) ? pause_code : '0;
    end
  end

  assign soft_reset = soft_reset_reg;
  assign run_start  = run_start_reg;
  assign resume     = resume_reg;
  assign sw_data    = sw_data_reg;
  assign LED        = led_reg;

endmodule

// File: tb/tb_io_operator_ctrl.sv
// Bench for io_operator_ctrl: one instance with DEBOUNCE_CYCLES=1, one with 4.
module tb_io_operator_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run_b [2];
  logic       cont_b[2];
  logic       preq  [2];
  logic [9:0] sw_v  [2];
  logic [9:0] code_v[2];
  logic       sr_o  [2];
  logic       rs_o  [2];
  logic       res_o [2];
  logic [9:0] swd_o [2];
  logic [9:0] led_o [2];

  int rs_cnt [2] = '{0, 0};
  int res_cnt[2] = '{0, 0};
  int dcy    [2] = '{1, 4};
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  io_operator_ctrl #(.DEBOUNCE_CYCLES(1), .SW_WIDTH(10)) dut0 (
    .Clk(clk), .Reset_n(rst_n), .Run(run_b[0]), .Continue(cont_b[0]), .SW(sw_v[0]),
    .pause_req(preq[0]), .pause_code(code_v[0]), .soft_reset(sr_o[0]),
    .run_start(rs_o[0]), .resume(res_o[0]), .sw_data(swd_o[0]), .LED(led_o[0])
  );

  io_operator_ctrl #(.DEBOUNCE_CYCLES(4), .SW_WIDTH(10)) dut1 (
    .Clk(clk), .Reset_n(rst_n), .Run(run_b[1]), .Continue(cont_b[1]), .SW(sw_v[1]),
    .pause_req(preq[1]), .pause_code(code_v[1]), .soft_reset(sr_o[1]),
    .run_start(rs_o[1]), .resume(res_o[1]), .sw_data(swd_o[1]), .LED(led_o[1])
  );

  // Pulse counters: the model only cares how many events happened.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rs_o[i])  rs_cnt[i]  <= rs_cnt[i] + 1;
      if (res_o[i]) res_cnt[i] <= res_cnt[i] + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold Continue low for w clocks, release, then let everything settle.
  task automatic pulse_cont(input int i, input int w);
    cont_b[i] = 1'b0;
    cyc(w);
    cont_b[i] = 1'b1;
    cyc(dcy[i] + 8);
  endtask

  task automatic chk_quiet(input int i, input string tag);
    chk($sformatf("%s_soft%0d", tag, i), 32'(sr_o[i]), 32'd0);
    chk($sformatf("%s_run%0d", tag, i), 32'(rs_o[i]), 32'd0);
    chk($sformatf("%s_res%0d", tag, i), 32'(res_o[i]), 32'd0);
    chk($sformatf("%s_swd%0d", tag, i), 32'(swd_o[i]), 32'd0);
    chk($sformatf("%s_led%0d", tag, i), 32'(led_o[i]), 32'd0);
  endtask

  initial begin
    int         b;
    logic [9:0] exp_sw0;
    logic [9:0] exp_sw1;

    // Reset with arbitrary inputs
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      run_b[i]  = 1'($urandom);
      cont_b[i] = 1'($urandom);
      preq[i]   = 1'($urandom);
      sw_v[i]   = 10'($urandom);
      code_v[i] = 10'($urandom);
    end
    #12;
    for (int i = 0; i < 2; i++) chk_quiet(i, "reset");
    for (int i = 0; i < 2; i++) begin
      run_b[i] = 1'b1; cont_b[i] = 1'b1; preq[i] = 1'b0;
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    for (int i = 0; i < 2; i++) chk_quiet(i, "post_reset");

    // Soft reset and run_start (instance 0)
    b = rs_cnt[0];
    run_b[0] = 1'b0; cont_b[0] = 1'b0;
    cyc(4);
    chk("soft_on", 32'(sr_o[0]), 32'd1);
    cyc(2);
    chk("soft_hold", 32'(sr_o[0]), 32'd1);
    cont_b[0] = 1'b1;
    cyc(6);
    chk("soft_off", 32'(sr_o[0]), 32'd0);
    run_b[0] = 1'b1;
    cyc(6);
    chk("soft_end_no_start", 32'(rs_cnt[0] - b), 32'd0);
    run_b[0] = 1'b0; cyc(1); run_b[0] = 1'b1;
    cyc(8);
    chk("run_start_one", 32'(rs_cnt[0] - b), 32'd1);
    chk("soft_no_resume", 32'(res_cnt[0]), 32'd0);

    // run_start through the longer debouncer (instance 1)
    b = rs_cnt[1];
    run_b[1] = 1'b0; cyc(3); run_b[1] = 1'b1;
    cyc(12);
    chk("run_glitch_db4", 32'(rs_cnt[1] - b), 32'd0);
    run_b[1] = 1'b0; cyc(5); run_b[1] = 1'b1;
    cyc(12);
    chk("run_start_db4", 32'(rs_cnt[1] - b), 32'd1);

    // Pause with SW capture (instance 0)
    code_v[0] = 10'h3A5;
    preq[0] = 1'b1;
    cyc(3);
    chk("pause_led", 32'(led_o[0]), 32'h3A5);
    sw_v[0] = 10'b0010110110;
    cyc(3);
    b = res_cnt[0];
    pulse_cont(0, 1);
    chk("cap1_swd", 32'(swd_o[0]), 32'h0B6);
    chk("cap1_resume", 32'(res_cnt[0] - b), 32'd1);
    chk("cap1_ack_led", 32'(led_o[0]), 32'd0);
    preq[0] = 1'b0;
    cyc(3);

    // Back-to-back pause; a press in ACK must not resume again
    sw_v[0] = 10'b1100101101;
    preq[0] = 1'b1;
    cyc(3);
    b = res_cnt[0];
    pulse_cont(0, 1);
    chk("cap2_swd", 32'(swd_o[0]), 32'h32D);
    chk("cap2_resume", 32'(res_cnt[0] - b), 32'd1);
    sw_v[0] = 10'h155;
    cyc(10);
    pulse_cont(0, 2);
    chk("ack_no_resume", 32'(res_cnt[0] - b), 32'd1);
    chk("ack_no_capture", 32'(swd_o[0]), 32'h32D);
    preq[0] = 1'b0;
    cyc(3);
    exp_sw0 = 10'h32D;

    // Randomized handshakes with glitches (instance 1)
    exp_sw1 = 10'h000;
    for (int k = 0; k < 6; k++) begin
      code_v[1] = 10'($urandom);
      preq[1] = 1'b1;
      cyc(3);
      chk($sformatf("rnd%0d_led", k), 32'(led_o[1]), 32'(code_v[1]));
      code_v[1] = 10'($urandom);
      cyc(2);
      chk($sformatf("rnd%0d_led_track", k), 32'(led_o[1]), 32'(code_v[1]));
      sw_v[1] = exp_sw1 ^ 10'($urandom_range(1, 1023));
      cyc(3);
      b = res_cnt[1];
      pulse_cont(1, $urandom_range(1, 3));
      chk($sformatf("rnd%0d_glitch_swd", k), 32'(swd_o[1]), 32'(exp_sw1));
      chk($sformatf("rnd%0d_glitch_res", k), 32'(res_cnt[1] - b), 32'd0);
      pulse_cont(1, $urandom_range(4, 8));
      exp_sw1 = sw_v[1];
      chk($sformatf("rnd%0d_swd", k), 32'(swd_o[1]), 32'(exp_sw1));
      chk($sformatf("rnd%0d_res", k), 32'(res_cnt[1] - b), 32'd1);
      chk($sformatf("rnd%0d_ack_led", k), 32'(led_o[1]), 32'd0);
      preq[1] = 1'b0;
      cyc(3);
    end

    // Continue already held when the pause begins (instance 1)
    cont_b[1] = 1'b0;
    cyc(12);
    sw_v[1] = exp_sw1 ^ 10'($urandom_range(1, 1023));
    cyc(3);
    preq[1] = 1'b1;
    cyc(10);
    b = res_cnt[1];
    chk("preheld_swd", 32'(swd_o[1]), 32'(exp_sw1));
    cont_b[1] = 1'b1;
    cyc(12);
    chk("preheld_rel_swd", 32'(swd_o[1]), 32'(exp_sw1));
    chk("preheld_rel_res", 32'(res_cnt[1] - b), 32'd0);
    pulse_cont(1, 5);
    exp_sw1 = sw_v[1];
    chk("repress_swd", 32'(swd_o[1]), 32'(exp_sw1));
    chk("repress_res", 32'(res_cnt[1] - b), 32'd1);
    preq[1] = 1'b0;
    cyc(3);

    // Abort in WAIT_RELEASE (instance 0)
    sw_v[0] = exp_sw0 ^ 10'($urandom_range(1, 1023));
    cyc(3);
    preq[0] = 1'b1;
    cyc(3);
    b = res_cnt[0];
    cont_b[0] = 1'b0;
    cyc(6);
    exp_sw0 = sw_v[0];
    chk("abort_cap_swd", 32'(swd_o[0]), 32'(exp_sw0));
    preq[0] = 1'b0;
    cyc(3);
    chk("abort_led", 32'(led_o[0]), 32'd0);
    cont_b[0] = 1'b1;
    cyc(8);
    chk("abort_no_resume", 32'(res_cnt[0] - b), 32'd0);
    chk("abort_swd_kept", 32'(swd_o[0]), 32'(exp_sw0));

    // Asynchronous reset in WAIT_PRESS (instance 0)
    code_v[0] = 10'($urandom) | 10'h001;
    preq[0] = 1'b1;
    cyc(4);
    chk("wp_led", 32'(led_o[0]), 32'(code_v[0]));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_led", 32'(led_o[0]), 32'd0);
    chk("async_swd", 32'(swd_o[0]), 32'd0);
    chk("async_res", 32'(res_o[0]), 32'd0);
    preq[0] = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("after_async_led", 32'(led_o[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/io_operator_ctrl.md
# io_operator_ctrl

Operator-side responder for the SLC-3 front-panel protocol. Receives the raw Run/Continue push buttons and the SW bank, synchronizes and debounces them, and converts them into clean single-cycle control events for the CPU. It also implements the pause/continue I/O handshake: while the CPU is paused it shows the CPU's pause code on LED, captures SW on the Continue press, and signals resume. Sits between the board pins and the slc3 datapath/controller inside slc3_top.

## Interface
- DEBOUNCE_CYCLES, 1, consecutive stable cycles needed to accept a button change (≥1; board builds override, e.g. 500000)
- SW_WIDTH, 10, switch/LED width
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset; one clock domain only
- Run  in  1  raw Run button, active-low (pressed = 0)
- Continue  in  1  raw Continue button, active-low
- SW  in  SW_WIDTH  raw switch bank
- pause_req  in  1  CPU is in a pause state, level
- pause_code  in  SW_WIDTH  code to display while paused (IR[9:0])
- soft_reset  out  1  level, high while Run and Continue are both debounced-pressed
- run_start  out  1  one-cycle pulse on debounced Run release, Continue not pressed
- resume  out  1  one-cycle pulse completing a pause handshake
- sw_data  out  SW_WIDTH  SW captured at the accepted Continue press
- LED  out  SW_WIDTH  pause_code while paused, else 0

## Operation
- Each button: 2-flop synchronizer, then debouncer. Debounced state flips only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch-free cycle clears the counter. SW passes through a 2-flop synchronizer and is not debounced.
- soft_reset has priority. While asserted: run_start, resume and sw_data capture are suppressed, and the FSM is forced to IDLE.
- run_start: debounced Run goes 0→1 while debounced Continue = 1 and soft_reset was low in the previous cycle. The Run release that ends a soft reset produces no pulse.
- Pause FSM states:
  - IDLE: LED = 0. If pause_req = 1, go to WAIT_PRESS.
  - WAIT_PRESS: LED = pause_code. On debounced Continue 1→0, load sw_data from synchronized SW, then go to WAIT_RELEASE.
  - WAIT_RELEASE: LED = pause_code. On debounced Continue 0→1, assert resume for one cycle and go to ACK.
  - ACK: LED = 0. Wait for pause_req = 0, then go to IDLE. This is a 4-phase handshake; a second pause needs pause_req to fall and rise again.
- If pause_req drops in WAIT_PRESS or WAIT_RELEASE, return to IDLE with no resume and sw_data unchanged.
- If Continue is already pressed when pause_req rises, it is ignored until it has been released and pressed again. A press is accepted only as an edge seen in WAIT_PRESS.
- Reset values (Reset_n = 0, asynchronous):
  - FSM in IDLE
  - sw_data = 0, LED = 0
  - soft_reset = 0, run_start = 0, resume = 0
  - Debounced states = 1 (released); synchronizers = 1; counters = 0.
- Asserting Reset_n mid-handshake aborts it immediately; no pulse is emitted.

## Timing
- Button latency from pin change to debounced change: 2 sync cycles + DEBOUNCE_CYCLES.
- With DEBOUNCE_CYCLES = 1, a press held for one clock is accepted.
- Events are registered: run_start and resume go high the cycle after the debounced edge and last exactly one cycle.
- sw_data updates the cycle after the debounced Continue falling edge. It holds the SW value synchronized 2 cycles before that edge.
- LED is registered; it follows pause_code one cycle after entering WAIT_PRESS and tracks it while paused.
- Minimum handshake: pause_req high → WAIT_PRESS next cycle; resume no earlier than press latency + release latency.

## Structure
- Package slc3_io_pkg:
  - io_state_t enum {IDLE, WAIT_PRESS, WAIT_RELEASE, ACK}
  - SW_WIDTH default constant
  - function for debounce counter width: $clog2(DEBOUNCE_CYCLES+1)
- Sub-module button_debounce (synchronizer + counter, parameter DEBOUNCE_CYCLES, output debounced level and rise/fall strobes), instantiated twice, for Run and Continue.
- Pause FSM, SW synchronizer and output registers live in io_operator_ctrl.

## Test plan
- Reset: Reset_n = 0 with arbitrary inputs → all outputs 0 and FSM in IDLE. Release reset → outputs stay 0.
- Soft reset / start: Run = 0 and Continue = 0 together for 4 cycles → soft_reset high, no pulses. Release Continue, then Run → no run_start. Then Run low 1 cycle, high → one run_start pulse.
- Pause with SW capture: pause_req = 1, pause_code = 10'h3A5 → LED = 10'h3A5. SW = 10'b0010110110, Continue low 1 cycle → sw_data = 10'h0B6, one resume pulse, LED = 0 in ACK. Drop pause_req → IDLE.
- Back-to-back pauses: second pause with SW = 10'b1100101101 → sw_data = 10'h32D. Holding pause_req high after resume produces no second resume.
- Debounce: DEBOUNCE_CYCLES = 4, Continue glitches low for 3 cycles → no capture. Low for 4 cycles → capture. Pre-held Continue at pause entry is ignored until re-pressed.
- Abort: pause_req drops in WAIT_RELEASE → IDLE, no resume, sw_data keeps its captured value. Reset_n asserted in WAIT_PRESS → immediate IDLE.
